// File: rtl/cv32e40p_wb_pkg.sv
// Shared types and constants for the register-file write-back block.
// The wb_req_t field widths set the default ADDR_WIDTH/DATA_WIDTH of the top.
package cv32e40p_wb_pkg;

  localparam int unsigned WB_ADDR_WIDTH    = 6;
  localparam int unsigned WB_DATA_WIDTH    = 32;
  localparam int unsigned STARVE_LIMIT     = 4;
  localparam int unsigned STARVE_CNT_WIDTH = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [WB_ADDR_WIDTH-1:0] addr;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_LSU  = 2'd1,
    SRC_APU  = 2'd2
  } port_b_src_e;

endpackage

// File: rtl/cv32e40p_rf_writeback_if.sv
// Result handshakes and register-file write ports of the write-back block.
// The master modport is the producer/test side, the slave modport is the block itself.
interface cv32e40p_rf_writeback_if #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                    alu_valid_i;
  logic                    alu_ready_o;
  logic [ADDR_WIDTH-1:0]   alu_waddr_i;
  logic [DATA_WIDTH-1:0]   alu_wdata_i;

  logic                    lsu_valid_i;
  logic                    lsu_ready_o;
  logic [ADDR_WIDTH-1:0]   lsu_waddr_i;
  logic [DATA_WIDTH-1:0]   lsu_wdata_i;

  logic                    apu_valid_i;
  logic                    apu_ready_o;
  logic [ADDR_WIDTH-1:0]   apu_waddr_i;
  logic [DATA_WIDTH-1:0]   apu_wdata_i;

  logic [ADDR_WIDTH-1:0]   waddr_a_o;
  logic [DATA_WIDTH-1:0]   wdata_a_o;
  logic                    we_a_o;
  logic [ADDR_WIDTH-1:0]   waddr_b_o;
  logic [DATA_WIDTH-1:0]   wdata_b_o;
  logic                    we_b_o;
  logic [2**ADDR_WIDTH-1:0] pending_o;

  modport master (
    output alu_valid_i, alu_waddr_i, alu_wdata_i,
    output lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    output apu_valid_i, apu_waddr_i, apu_wdata_i,
    input  alu_ready_o, lsu_ready_o, apu_ready_o,
    input  waddr_a_o, wdata_a_o, we_a_o,
    input  waddr_b_o, wdata_b_o, we_b_o, pending_o
  );

  modport slave (
    input  alu_valid_i, alu_waddr_i, alu_wdata_i,
    input  lsu_valid_i, lsu_waddr_i, lsu_wdata_i,
    input  apu_valid_i, apu_waddr_i, apu_wdata_i,
    output alu_ready_o, lsu_ready_o, apu_ready_o,
    output waddr_a_o, wdata_a_o, we_a_o,
    output waddr_b_o, wdata_b_o, we_b_o, pending_o
  );

endinterface

// File: rtl/cv32e40p_wb_fifo.sv
// Load-result FIFO; DEPTH must be a power of two (pointers wrap naturally).
// Exposes per-entry valid/address so the top can decode hazards and pending bits.
module cv32e40p_wb_fifo
  import cv32e40p_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  push_i,
  input  wb_req_t                               push_req_i,
  input  logic                                  pop_i,
  output logic                                  full_o,
  output logic                                  empty_o,
  output wb_req_t                               head_o,
  output logic [DEPTH-1:0]                      entry_valid_o,
  output logic [DEPTH-1:0][WB_ADDR_WIDTH-1:0]   entry_addr_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  wb_req_t            mem_q [DEPTH];
  logic [DEPTH-1:0]   valid_q, valid_d;
  logic [PTR_W-1:0]   wptr_q, rptr_q;
  logic               do_push, do_pop;

  assign full_o        = &valid_q;
  assign empty_o       = ~|valid_q;
  assign do_pop        = pop_i && !empty_o;
  assign do_push       = push_i && (!full_o || do_pop);
  assign head_o        = mem_q[rptr_q];
  assign entry_valid_o = valid_q;

  // On push+pop while full both pointers coincide, so the set must win over the clear.
  always_comb begin
    valid_d = valid_q;
    if (do_pop)  valid_d[rptr_q] = 1'b0;
    if (do_push) valid_d[wptr_q] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      if (do_push) wptr_q <= wptr_q + PTR_W'(1);
      if (do_pop)  rptr_q <= rptr_q + PTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= push_req_i;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry_addr
    assign entry_addr_o[i] = mem_q[i].addr;
  end

endmodule

// File: rtl/cv32e40p_rf_writeback.sv
// Register-file write-back: ALU on port A, LSU FIFO and APU arbitrated onto port B.
// Define CV32E40P_WB_STARVE_GUARD_EN to let a waiting APU through after STARVE_LIMIT FIFO grants.
module cv32e40p_rf_writeback
  import cv32e40p_wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = WB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = WB_DATA_WIDTH,
  parameter int unsigned LSU_FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  cv32e40p_rf_writeback_if.slave wb
);

  localparam int unsigned NREG = 2**ADDR_WIDTH;

  wb_req_t                                       lsu_req, apu_req, fifo_head, b_win_req;
  logic                                          fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [LSU_FIFO_DEPTH-1:0]                     fifo_vld;
  logic [LSU_FIFO_DEPTH-1:0][WB_ADDR_WIDTH-1:0]  fifo_addr;
  port_b_src_e                                   b_src;
  logic                                          starve_hit;
  logic                                          alu_hazard, alu_fire, lsu_fire;
  logic [NREG-1:0]                               pending;

  logic                  we_a_q, we_b_q;
  logic [ADDR_WIDTH-1:0] waddr_a_q, waddr_b_q;
  logic [DATA_WIDTH-1:0] wdata_a_q, wdata_b_q;

  assign lsu_req.addr = wb.lsu_waddr_i;
  assign lsu_req.data = wb.lsu_wdata_i;
  assign apu_req.addr = wb.apu_waddr_i;
  assign apu_req.data = wb.apu_wdata_i;

  cv32e40p_wb_fifo #(
    .DEPTH (LSU_FIFO_DEPTH)
  ) u_lsu_fifo (
    .clk           (clk),
    .rst           (rst),
    .push_i        (fifo_push),
    .push_req_i    (lsu_req),
    .pop_i         (fifo_pop),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .head_o        (fifo_head),
    .entry_valid_o (fifo_vld),
    .entry_addr_o  (fifo_addr)
  );

`ifdef CV32E40P_WB_STARVE_GUARD_EN
  logic [STARVE_CNT_WIDTH-1:0] starve_q, starve_d;

  assign starve_hit = (starve_q == STARVE_CNT_WIDTH'(STARVE_LIMIT));

  always_comb begin
    starve_d = starve_q;
    if (!wb.apu_valid_i || b_src == SRC_APU) starve_d = '0;
    else if (b_src == SRC_LSU && !starve_hit) starve_d = starve_q + STARVE_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) starve_q <= '0;
    else     starve_q <= starve_d;
  end
`else
  assign starve_hit = 1'b0;
`endif

  always_comb begin
    b_src = SRC_NONE;
    if (!rst) begin
      if (wb.apu_valid_i && (fifo_empty || starve_hit)) b_src = SRC_APU;
      else if (!fifo_empty)                             b_src = SRC_LSU;
    end
  end

  assign b_win_req      = (b_src == SRC_APU) ? apu_req : fifo_head;
  assign fifo_pop       = (b_src == SRC_LSU);
  assign wb.apu_ready_o = (b_src == SRC_APU);
  assign wb.lsu_ready_o = !rst && (!fifo_full || fifo_pop);
  assign lsu_fire       = wb.lsu_valid_i && wb.lsu_ready_o;
  assign fifo_push      = lsu_fire && (wb.lsu_waddr_i != '0);

  // Anything heading for port B is older than the ALU result, so the ALU waits behind it.
  always_comb begin
    alu_hazard = 1'b0;
    for (int i = 0; i < LSU_FIFO_DEPTH; i++) begin
      if (fifo_vld[i] && fifo_addr[i] == wb.alu_waddr_i) alu_hazard = 1'b1;
    end
    if (wb.lsu_valid_i && wb.lsu_waddr_i == wb.alu_waddr_i)       alu_hazard = 1'b1;
    if (b_src != SRC_NONE && b_win_req.addr == wb.alu_waddr_i)    alu_hazard = 1'b1;
    if (we_b_q && waddr_b_q == wb.alu_waddr_i)                    alu_hazard = 1'b1;
    if (wb.alu_waddr_i == '0)                                     alu_hazard = 1'b0;
  end

  assign wb.alu_ready_o = !rst && !alu_hazard;
  assign alu_fire       = wb.alu_valid_i && wb.alu_ready_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_a_q    <= 1'b0;
      waddr_a_q <= '0;
      wdata_a_q <= '0;
    end else begin
      we_a_q <= alu_fire && (wb.alu_waddr_i != '0);
      if (alu_fire) begin
        waddr_a_q <= wb.alu_waddr_i;
        wdata_a_q <= wb.alu_wdata_i;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_b_q    <= 1'b0;
      waddr_b_q <= '0;
      wdata_b_q <= '0;
    end else begin
      we_b_q <= (b_src != SRC_NONE) && (b_win_req.addr != '0);
      if (b_src != SRC_NONE) begin
        waddr_b_q <= b_win_req.addr;
        wdata_b_q <= b_win_req.data;
      end
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < LSU_FIFO_DEPTH; i++) begin
      if (fifo_vld[i]) pending[fifo_addr[i]] = 1'b1;
    end
    if (we_b_q) pending[waddr_b_q] = 1'b1;
    pending[0] = 1'b0;
  end

  assign wb.we_a_o    = we_a_q;
  assign wb.waddr_a_o = waddr_a_q;
  assign wb.wdata_a_o = wdata_a_q;
  assign wb.we_b_o    = we_b_q;
  assign wb.waddr_b_o = waddr_b_q;
  assign wb.wdata_b_o = wdata_b_q;
  assign wb.pending_o = pending;

endmodule

// File: tb/tb_cv32e40p_rf_writeback.sv
// Self-checking bench for cv32e40p_rf_writeback: directed scenarios plus random traffic
// checked cycle by cycle against a queue-based reference model.
module tb_cv32e40p_rf_writeback;

`ifdef CV32E40P_WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif
  localparam int DEPTH  = 4;
  localparam int SLIMIT = 4;

  typedef struct packed {
    logic [5:0]  a;
    logic [31:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cv32e40p_rf_writeback_if #(.ADDR_WIDTH(6), .DATA_WIDTH(32)) wbif ();

  cv32e40p_rf_writeback #(
    .ADDR_WIDTH     (6),
    .DATA_WIDTH     (32),
    .LSU_FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wbif)
  );

  int nvec = 0;
  int nerr = 0;

  // requests currently offered by the bench (held until the model says they transferred)
  logic        r_alu_v = 0, r_lsu_v = 0, r_apu_v = 0;
  logic [5:0]  r_alu_a = 0, r_lsu_a = 0, r_apu_a = 0;
  logic [31:0] r_alu_d = 0, r_lsu_d = 0, r_apu_d = 0;

  // reference model
  ent_t        q[$];
  int          starve = 0;
  logic        ea_we = 0, eb_we = 0;
  logic [5:0]  ea_a = 0, eb_a = 0;
  logic [31:0] ea_d = 0, eb_d = 0;

  logic [31:0] rf_obs [64];
  logic [5:0]  b_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    wbif.alu_valid_i = r_alu_v; wbif.alu_waddr_i = r_alu_a; wbif.alu_wdata_i = r_alu_d;
    wbif.lsu_valid_i = r_lsu_v; wbif.lsu_waddr_i = r_lsu_a; wbif.lsu_wdata_i = r_lsu_d;
    wbif.apu_valid_i = r_apu_v; wbif.apu_waddr_i = r_apu_a; wbif.apu_wdata_i = r_apu_d;
  endtask

  function automatic logic [63:0] exp_pending();
    logic [63:0] p = '0;
    foreach (q[i]) p[q[i].a] = 1'b1;
    if (eb_we) p[eb_a] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  // One clock: enter and leave at a falling edge.
  task automatic cycle();
    logic apu_win, lsu_win, alu_rdy, lsu_rdy, alu_f, lsu_f, apu_f;
    logic [5:0] win_a;
    ent_t e;
    drive();
    #1;
    apu_win = r_apu_v && (q.size() == 0 || (GUARD && starve >= SLIMIT));
    lsu_win = !apu_win && q.size() != 0;
    lsu_rdy = (q.size() < DEPTH) || lsu_win;
    win_a   = apu_win ? r_apu_a : (lsu_win ? q[0].a : 6'd0);
    alu_rdy = 1'b1;
    if (r_alu_a != 6'd0) begin
      foreach (q[i]) if (q[i].a == r_alu_a) alu_rdy = 1'b0;
      if (r_lsu_v && r_lsu_a == r_alu_a)                alu_rdy = 1'b0;
      if ((apu_win || lsu_win) && win_a == r_alu_a)     alu_rdy = 1'b0;
      if (eb_we && eb_a == r_alu_a)                     alu_rdy = 1'b0;
    end
    chk("alu_ready", wbif.alu_ready_o, alu_rdy);
    chk("lsu_ready", wbif.lsu_ready_o, lsu_rdy);
    chk("apu_ready", wbif.apu_ready_o, apu_win);
    alu_f = r_alu_v && alu_rdy;
    lsu_f = r_lsu_v && lsu_rdy;
    apu_f = apu_win;
    @(posedge clk);
    ea_we = alu_f && r_alu_a != 6'd0;
    if (alu_f) begin ea_a = r_alu_a; ea_d = r_alu_d; end
    eb_we = 1'b0;
    if (apu_win) begin
      eb_we = r_apu_a != 6'd0; eb_a = r_apu_a; eb_d = r_apu_d;
    end else if (lsu_win) begin
      e = q.pop_front(); eb_we = 1'b1; eb_a = e.a; eb_d = e.d;
    end
    if (lsu_f && r_lsu_a != 6'd0) q.push_back('{a: r_lsu_a, d: r_lsu_d});
    if (GUARD) begin
      if (!r_apu_v || apu_win) starve = 0;
      else if (lsu_win && starve < SLIMIT) starve++;
    end
    if (alu_f) r_alu_v = 1'b0;
    if (lsu_f) r_lsu_v = 1'b0;
    if (apu_f) r_apu_v = 1'b0;
    @(negedge clk);
    chk("we_a", wbif.we_a_o, ea_we);
    if (ea_we) begin
      chk("waddr_a", wbif.waddr_a_o, ea_a);
      chk("wdata_a", wbif.wdata_a_o, ea_d);
    end
    chk("we_b", wbif.we_b_o, eb_we);
    if (eb_we) begin
      chk("waddr_b", wbif.waddr_b_o, eb_a);
      chk("wdata_b", wbif.wdata_b_o, eb_d);
    end
    chk("pending", wbif.pending_o, exp_pending());
    if (wbif.we_b_o) begin
      rf_obs[wbif.waddr_b_o] = wbif.wdata_b_o;
      b_log.push_back(wbif.waddr_b_o);
    end
    if (wbif.we_a_o) rf_obs[wbif.waddr_a_o] = wbif.wdata_a_o;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_we_a", wbif.we_a_o, 0);
    chk("rst_waddr_a", wbif.waddr_a_o, 0);
    chk("rst_wdata_a", wbif.wdata_a_o, 0);
    chk("rst_we_b", wbif.we_b_o, 0);
    chk("rst_waddr_b", wbif.waddr_b_o, 0);
    chk("rst_wdata_b", wbif.wdata_b_o, 0);
    chk("rst_pending", wbif.pending_o, 0);
    chk("rst_alu_ready", wbif.alu_ready_o, 0);
    chk("rst_lsu_ready", wbif.lsu_ready_o, 0);
    chk("rst_apu_ready", wbif.apu_ready_o, 0);
    q.delete();
    starve = 0; ea_we = 0; eb_we = 0;
    r_alu_v = 0; r_lsu_v = 0; r_apu_v = 0;
    drive();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic drain(input int max);
    int n = 0;
    while ((r_alu_v || r_lsu_v || r_apu_v) && n < max) begin
      cycle();
      n++;
    end
    chk("drain_timeout", {r_alu_v, r_lsu_v, r_apu_v}, 0);
  endtask

  task automatic random_phase(input int ncyc, input int p_alu, input int p_lsu, input int p_apu);
    for (int c = 0; c < ncyc; c++) begin
      if (!r_alu_v && $urandom_range(99) < p_alu) begin
        r_alu_v = 1; r_alu_a = 6'($urandom_range(0, 15)); r_alu_d = $urandom;
      end
      if (!r_lsu_v && $urandom_range(99) < p_lsu) begin
        r_lsu_v = 1; r_lsu_a = 6'($urandom_range(0, 15)); r_lsu_d = $urandom;
      end
      if (!r_apu_v && $urandom_range(99) < p_apu) begin
        r_apu_v = 1; r_apu_a = 6'($urandom_range(0, 15)) | (($urandom_range(0, 3) == 0) ? 6'h20 : 6'h00);
        r_apu_d = $urandom;
      end
      cycle();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    int idx;
    int n;
    drive();
    do_reset();
    idle(2);

    // single ALU write
    r_alu_v = 1; r_alu_a = 6'd7; r_alu_d = 32'hDEADBEEF;
    cycle();
    chk("alu7_we", wbif.we_a_o, 1);
    chk("alu7_addr", wbif.waddr_a_o, 7);
    chk("alu7_data", wbif.wdata_a_o, 32'hDEADBEEF);
    cycle();
    chk("alu7_we_low", wbif.we_a_o, 0);

    // five back-to-back loads
    b_log.delete();
    for (int k = 1; k <= 5; k++) begin
      r_lsu_v = 1; r_lsu_a = 6'(k); r_lsu_d = 32'h5000 + k;
      n = 0;
      while (r_lsu_v && n < 8) begin cycle(); n++; end
    end
    idle(4);
    chk("lsu5_count", b_log.size(), 5);
    for (int i = 0; i < 5 && i < b_log.size(); i++) chk("lsu5_order", b_log[i], 64'(i + 1));

    // LSU streaming while the APU waits
    b_log.delete();
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin r_apu_v = 1; r_apu_a = 6'd9; r_apu_d = 32'h0000A9A9; end
      r_lsu_v = 1; r_lsu_a = 6'(10 + k); r_lsu_d = 32'h7000 + k;
      n = 0;
      while (r_lsu_v && n < 8) begin cycle(); n++; end
    end
    drain(30);
    idle(4);
    idx = -1;
    foreach (b_log[i]) if (b_log[i] == 6'd9 && idx < 0) idx = i;
    chk("starve_apu_slot", 64'(idx), GUARD ? 64'd5 : 64'd8);

    // ALU held behind an in-flight load to the same register
    r_lsu_v = 1; r_lsu_a = 6'd3; r_lsu_d = 32'h11110003;
    cycle();
    r_alu_v = 1; r_alu_a = 6'd3; r_alu_d = 32'hA5A50003;
    stalls = 0;
    for (int i = 0; i < 10 && r_alu_v; i++) begin
      cycle();
      if (r_alu_v) stalls++;
    end
    idle(2);
    chk("hazard_stalls", stalls, 2);
    chk("hazard_final_r3", rf_obs[3], 32'hA5A50003);

    // every source writing register 0
    r_alu_v = 1; r_alu_a = 0; r_alu_d = 32'h1;
    r_lsu_v = 1; r_lsu_a = 0; r_lsu_d = 32'h2;
    r_apu_v = 1; r_apu_a = 0; r_apu_d = 32'h3;
    drain(10);
    chk("zero_we_a", wbif.we_a_o, 0);
    chk("zero_we_b", wbif.we_b_o, 0);
    chk("zero_pending0", wbif.pending_o[0], 0);
    idle(2);

    // random traffic, then a reset in the middle of it
    random_phase(400, 40, 70, 30);
    random_phase(400, 70, 90, 60);
    do_reset();
    cycle();
    chk("post_rst_we_a", wbif.we_a_o, 0);
    chk("post_rst_we_b", wbif.we_b_o, 0);
    idle(2);
    random_phase(300, 50, 80, 50);
    drain(40);
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
